// File: rtl/exc_seq_if.sv
// Decoder-to-CP0 exception sequencer bundle.
// master: decoder/test side drives the strobes; slave: exc_seq drives the CP0 controls.
interface exc_seq_if #(
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic             is_syscall;
    logic             is_break;
    logic             is_teq;
    logic             is_eret;
    logic             is_mtc0;
    logic             teq_eq;
    logic [31:0]      pc_in;
    logic [31:0]      status_in;
    logic             cp0_mtc0;
    logic             cp0_eret;
    logic             cp0_exc;
    logic [3:0]       cp0_cause;
    logic [31:0]      cp0_pc;
    logic             pc_sel;
    logic             stall;
    logic [1:0]       depth;
    logic [CNT_W-1:0] exc_cnt;
    logic             ovf_flag;
    logic             unf_flag;

    modport master (
        output instr_valid, is_syscall, is_break, is_teq,
        output is_eret, is_mtc0, teq_eq, pc_in, status_in,
        input  cp0_mtc0, cp0_eret, cp0_exc, cp0_cause, cp0_pc,
        input  pc_sel, stall, depth, exc_cnt, ovf_flag, unf_flag
    );

    modport slave (
        input  instr_valid, is_syscall, is_break, is_teq,
        input  is_eret, is_mtc0, teq_eq, pc_in, status_in,
        output cp0_mtc0, cp0_eret, cp0_exc, cp0_cause, cp0_pc,
        output pc_sel, stall, depth, exc_cnt, ovf_flag, unf_flag
    );
endinterface

// File: rtl/exc_seq.sv
// Exception sequencer: qualifies decoder traps/eret/mtc0 and sequences CP0 strobes.
// Ports: clk, rst (async, active-low), bus (exc_seq_if.slave: decoder in, CP0/PC/stall out).
module exc_seq #(
    parameter int MAX_DEPTH = 3,
    parameter int CNT_W     = 16
) (
    input logic      clk,
    input logic      rst,
    exc_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ENTER,
        REDIRECT,
        RETURN
    } state_t;

    localparam logic [3:0] C_SYS = 4'b1000;
    localparam logic [3:0] C_BRK = 4'b1001;
    localparam logic [3:0] C_TEQ = 4'b1101;
    localparam logic [1:0] MAXD  = 2'(MAX_DEPTH);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       depth_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             unf_q;
    logic [3:0]       cause_q;
    logic [3:0]       cause_d;
    logic [31:0]      pc_q;

    logic sel_sys, sel_brk, sel_teq, sel_eret, sel_mtc0;
    logic q_sys, q_brk, q_teq, trap, room;
    logic take, drop, do_eret;
    logic mtc0_c, exc_c, eret_c, psel_c, stall_c;

    wire [31:0] st = bus.status_in;
    wire        iv = bus.instr_valid;

    // Strict priority: a higher strobe masks all lower ones,
    // even when that higher trap turns out unqualified.
    assign sel_sys  = iv & bus.is_syscall;
    assign sel_brk  = iv & bus.is_break & ~bus.is_syscall;
    assign sel_teq  = iv & bus.is_teq & ~bus.is_syscall
                    & ~bus.is_break;
    assign sel_eret = iv & bus.is_eret & ~bus.is_syscall
                    & ~bus.is_break & ~bus.is_teq;
    assign sel_mtc0 = iv & bus.is_mtc0 & ~bus.is_syscall
                    & ~bus.is_break & ~bus.is_teq & ~bus.is_eret;

    assign q_sys = sel_sys & st[0] & st[1];
    assign q_brk = sel_brk & st[0] & st[2];
    assign q_teq = sel_teq & bus.teq_eq & st[0] & st[3];
    assign trap  = q_sys | q_brk | q_teq;
    assign room  = depth_q < MAXD;

    always_comb begin
        state_d = state_q;
        cause_d = C_SYS;
        take    = 1'b0;
        drop    = 1'b0;
        do_eret = 1'b0;
        mtc0_c  = 1'b0;
        exc_c   = 1'b0;
        eret_c  = 1'b0;
        psel_c  = 1'b0;
        stall_c = 1'b0;
        if (q_brk) cause_d = C_BRK;
        if (q_teq) cause_d = C_TEQ;
        unique case (state_q)
            IDLE: begin
                mtc0_c = sel_mtc0;
                if (trap && room) begin
                    take    = 1'b1;
                    stall_c = 1'b1;
                    state_d = ENTER;
                end else if (trap) begin
                    drop = 1'b1;
                end else if (sel_eret) begin
                    do_eret = 1'b1;
                    stall_c = 1'b1;
                    state_d = RETURN;
                end
            end
            ENTER: begin
                exc_c   = 1'b1;
                stall_c = 1'b1;
                state_d = REDIRECT;
            end
            REDIRECT: begin
                psel_c  = 1'b1;
                stall_c = 1'b1;
                state_d = IDLE;
            end
            RETURN: begin
                eret_c  = 1'b1;
                psel_c  = 1'b1;
                stall_c = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            depth_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            cause_q <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                cause_q <= cause_d;
                pc_q    <= bus.pc_in;
                depth_q <= depth_q + 2'd1;
                if (~&cnt_q) cnt_q <= cnt_q + 1'b1;
            end
            if (drop) ovf_q <= 1'b1;
            if (do_eret) begin
                if (depth_q != '0) depth_q <= depth_q - 2'd1;
                else               unf_q   <= 1'b1;
            end
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign bus.cp0_mtc0  = rst & mtc0_c;
    assign bus.cp0_exc   = rst & exc_c;
    assign bus.cp0_eret  = rst & eret_c;
    assign bus.pc_sel    = rst & psel_c;
    assign bus.stall     = rst & stall_c;
    assign bus.cp0_cause = cause_q;
    assign bus.cp0_pc    = pc_q;
    assign bus.depth     = depth_q;
    assign bus.exc_cnt   = cnt_q;
    assign bus.ovf_flag  = ovf_q;
    assign bus.unf_flag  = unf_q;
endmodule

// File: tb/tb_exc_seq.sv
// Self-checking bench for exc_seq: queue-based reference model plus directed vectors.
// Compares every DUT output on each falling edge and pins key cycles with literals.
module tb_exc_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    exc_seq_if #(.CNT_W(16)) bus ();

    exc_seq #(
        .MAX_DEPTH(3),
        .CNT_W    (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: a queue of the per-cycle CP0 actions still owed.
    typedef struct {
        bit exc;
        bit eret;
        bit psel;
    } slot_t;

    slot_t       plan[$];
    int          m_depth;
    int          m_cnt;
    bit          m_ovf;
    bit          m_unf;
    logic [3:0]  m_cause;
    logic [31:0] m_pc;
    bit          e_exc, e_eret, e_psel, e_mtc0, e_stall;
    int          k_cmp;
    int          k_upd;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // 0 none, 1 syscall, 2 break, 3 teq, 4 eret, 5 mtc0
    function automatic int pick();
        if (!bus.instr_valid) return 0;
        if (bus.is_syscall)   return 1;
        if (bus.is_break)     return 2;
        if (bus.is_teq)       return 3;
        if (bus.is_eret)      return 4;
        if (bus.is_mtc0)      return 5;
        return 0;
    endfunction

    function automatic bit qual(int k);
        logic [31:0] s;
        s = bus.status_in;
        case (k)
            1:       return s[0] & s[1];
            2:       return s[0] & s[2];
            3:       return bus.teq_eq & s[0] & s[3];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] cause_of(int k);
        case (k)
            1:       return 4'b1000;
            2:       return 4'b1001;
            default: return 4'b1101;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            plan.delete();
            m_depth = 0;
            m_cnt   = 0;
            m_ovf   = 0;
            m_unf   = 0;
            m_cause = '0;
            m_pc    = '0;
        end else if (plan.size() > 0) begin
            void'(plan.pop_front());
        end else begin
            k_upd = pick();
            if (k_upd >= 1 && k_upd <= 3 && qual(k_upd)) begin
                if (m_depth < 3) begin
                    m_cause = cause_of(k_upd);
                    m_pc    = bus.pc_in;
                    m_depth++;
                    if (m_cnt < 65535) m_cnt++;
                    plan.push_back(slot_t'{1'b1, 1'b0, 1'b0});
                    plan.push_back(slot_t'{1'b0, 1'b0, 1'b1});
                end else begin
                    m_ovf = 1;
                end
            end else if (k_upd == 4) begin
                if (m_depth > 0) m_depth--;
                else             m_unf = 1;
                plan.push_back(slot_t'{1'b0, 1'b1, 1'b1});
            end
        end
    end

    always @(negedge clk) begin
        e_exc = 0; e_eret = 0; e_psel = 0; e_mtc0 = 0; e_stall = 0;
        if (rst) begin
            if (plan.size() > 0) begin
                e_exc   = plan[0].exc;
                e_eret  = plan[0].eret;
                e_psel  = plan[0].psel;
                e_stall = 1;
            end else begin
                k_cmp = pick();
                if (k_cmp >= 1 && k_cmp <= 3 && qual(k_cmp) && m_depth < 3)
                    e_stall = 1;
                if (k_cmp == 4) e_stall = 1;
                if (k_cmp == 5) e_mtc0  = 1;
            end
            chk("m_cause", bus.cp0_cause, m_cause);
            chk("m_pc", bus.cp0_pc, m_pc);
            chk("m_depth", bus.depth, m_depth);
            chk("m_cnt", bus.exc_cnt, m_cnt);
            chk("m_ovf", bus.ovf_flag, m_ovf);
            chk("m_unf", bus.unf_flag, m_unf);
        end else begin
            chk("r_cause", bus.cp0_cause, 0);
            chk("r_pc", bus.cp0_pc, 0);
            chk("r_depth", bus.depth, 0);
            chk("r_cnt", bus.exc_cnt, 0);
            chk("r_ovf", bus.ovf_flag, 0);
            chk("r_unf", bus.unf_flag, 0);
        end
        chk("m_exc", bus.cp0_exc, e_exc);
        chk("m_eret", bus.cp0_eret, e_eret);
        chk("m_psel", bus.pc_sel, e_psel);
        chk("m_mtc0", bus.cp0_mtc0, e_mtc0);
        chk("m_stall", bus.stall, e_stall);
    end

    function automatic void zero_in();
        bus.instr_valid = 0;
        bus.is_syscall  = 0;
        bus.is_break    = 0;
        bus.is_teq      = 0;
        bus.is_eret     = 0;
        bus.is_mtc0     = 0;
        bus.teq_eq      = 0;
        bus.pc_in       = '0;
        bus.status_in   = '0;
    endfunction

    task automatic send(bit s, bit b, bit t, bit eq, bit e, bit m,
                        logic [31:0] pc, logic [31:0] stv);
        @(posedge clk); #1;
        bus.instr_valid = 1;
        bus.is_syscall  = s;
        bus.is_break    = b;
        bus.is_teq      = t;
        bus.teq_eq      = eq;
        bus.is_eret     = e;
        bus.is_mtc0     = m;
        bus.pc_in       = pc;
        bus.status_in   = stv;
    endtask

    task automatic clear();
        @(posedge clk); #1;
        zero_in();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 0;
        zero_in();
        @(posedge clk); #1;
        rst = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        zero_in();
        rst = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        repeat (5) @(negedge clk);
        chk("idle_stall", bus.stall, 0);
        chk("idle_exc", bus.cp0_exc, 0);
        chk("idle_psel", bus.pc_sel, 0);
        chk("idle_depth", bus.depth, 0);
        chk("idle_cnt", bus.exc_cnt, 0);

        // qualified syscall
        send(1, 0, 0, 0, 0, 0, 32'h0040_0010, 32'h3);
        @(negedge clk);
        chk("sys_T_stall", bus.stall, 1);
        clear();
        @(negedge clk);
        chk("sys_exc", bus.cp0_exc, 1);
        chk("sys_cause", bus.cp0_cause, 4'b1000);
        chk("sys_pc", bus.cp0_pc, 32'h0040_0010);
        @(negedge clk);
        chk("sys_psel", bus.pc_sel, 1);
        chk("sys_depth", bus.depth, 1);
        chk("sys_cnt", bus.exc_cnt, 1);
        @(negedge clk);
        chk("sys_done", bus.stall, 0);

        // unqualified break
        send(0, 1, 0, 0, 0, 0, 32'h0000_0100, 32'h1);
        @(negedge clk);
        chk("brk_nq_stall", bus.stall, 0);
        clear();
        @(negedge clk);
        chk("brk_nq_exc", bus.cp0_exc, 0);
        chk("brk_nq_cnt", bus.exc_cnt, 1);

        // qualified break, strobe held through ENTER
        send(0, 1, 0, 0, 0, 0, 32'h0040_0020, 32'h5);
        @(posedge clk);
        @(negedge clk);
        chk("brk_exc", bus.cp0_exc, 1);
        chk("brk_cause", bus.cp0_cause, 4'b1001);
        clear();
        @(negedge clk);
        chk("brk_depth", bus.depth, 2);
        repeat (2) @(negedge clk);

        // two erets unwind depth 2 -> 0
        for (int i = 0; i < 2; i++) begin
            send(0, 0, 0, 0, 1, 0, '0, '0);
            clear();
            @(negedge clk);
            chk("eret_strobe", bus.cp0_eret, 1);
            chk("eret_depth", bus.depth, 1 - i);
            @(negedge clk);
        end
        chk("eret_unf", bus.unf_flag, 0);

        // lone mtc0
        send(0, 0, 0, 0, 0, 1, '0, '0);
        @(negedge clk);
        chk("mtc0_strobe", bus.cp0_mtc0, 1);
        chk("mtc0_stall", bus.stall, 0);
        clear();

        // nesting overflow
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(1, 0, 0, 0, 0, 0, 32'h1000 + 32'(i), 32'h3);
            @(negedge clk);
            chk("nest_stall", bus.stall, i < 3);
            clear();
            @(negedge clk);
            chk("nest_exc", bus.cp0_exc, i < 3);
            repeat (2) @(negedge clk);
            chk("nest_depth", bus.depth, (i < 3) ? i + 1 : 3);
        end
        chk("nest_ovf", bus.ovf_flag, 1);
        chk("nest_cnt", bus.exc_cnt, 3);
        chk("nest_pc", bus.cp0_pc, 32'h1002);

        // eret at depth 0
        do_reset();
        send(0, 0, 0, 0, 1, 0, '0, '0);
        clear();
        @(negedge clk);
        chk("unf_eret", bus.cp0_eret, 1);
        chk("unf_psel", bus.pc_sel, 1);
        chk("unf_flag", bus.unf_flag, 1);
        chk("unf_depth", bus.depth, 0);
        @(negedge clk);

        // teq beats mtc0, then reset during ENTER
        send(0, 0, 1, 1, 0, 1, 32'h0040_0030, 32'h9);
        @(negedge clk);
        chk("teq_mtc0", bus.cp0_mtc0, 0);
        chk("teq_stall", bus.stall, 1);
        clear();
        @(negedge clk);
        chk("teq_exc", bus.cp0_exc, 1);
        chk("teq_cause", bus.cp0_cause, 4'b1101);
        #1 rst = 0;
        #1;
        chk("arst_exc", bus.cp0_exc, 0);
        chk("arst_stall", bus.stall, 0);
        chk("arst_cause", bus.cp0_cause, 0);
        chk("arst_pc", bus.cp0_pc, 0);
        chk("arst_depth", bus.depth, 0);
        chk("arst_cnt", bus.exc_cnt, 0);
        chk("arst_unf", bus.unf_flag, 0);
        @(posedge clk); #1 rst = 1;
        repeat (3) @(negedge clk);
        chk("post_psel", bus.pc_sel, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
